// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e : scheduler states (IDLE / SEND_LO / SEND_HI)
//   idx_width() : bits needed to index n_req requesters (minimum 1)
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND_LO = 2'b01,
    SEND_HI = 2'b10
  } arb_state_e;

  // ceil(log2(n)), never less than 1 so a 1-bit index still exists.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin selector.
//   req   : request vector, one bit per requester
//   last  : index granted most recently (lowest priority this round)
//   found : at least one request is set
//   idx   : first set request searching from last+1 upward, wrapping
module fifo_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from the lowest priority (last itself) to the highest (last+1), so
  // the final hit that sticks is the closest one after last.
  always_comb begin
    // NOTE: every output gets a default before the loop; without it a
    // combinational block that assigns conditionally infers a latch.
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-domain scheduler sharing one async-FIFO write port among N_REQ
// requesters. Grants round-robin, serialises each request into one or two
// D_SIZE frames and only writes while the FIFO is not full.
//   clk, rst  : write-domain clock, asynchronous active-high reset
//   req       : per-requester request level, held until ack
//   req_two   : per-requester two-frame flag (low frame first)
//   req_data  : packed payloads, 2*D_SIZE bits per requester
//   fifo_full : FIFO full flag
//   ack       : one-hot, one-cycle capture pulse
//   w_inc     : FIFO write enable
//   w_data    : FIFO write data
//   grant_id  : index of current/last granted requester
//   busy      : high whenever a transfer is in progress
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int D_SIZE = 8,
  parameter int N_REQ  = 4,
  parameter int IDX_W  = idx_width(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_two,
  input  logic [N_REQ*2*D_SIZE-1:0] req_data,
  input  logic                      fifo_full,
  output logic [N_REQ-1:0]          ack,
  output logic                      w_inc,
  output logic [D_SIZE-1:0]         w_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy
);

  arb_state_e state, state_next;

  logic [IDX_W-1:0]    last;
  logic [2*D_SIZE-1:0] hold;
  logic                hold_two;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                take_grant;
  logic [2*D_SIZE-1:0] payload [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_payload
    assign payload[g] = req_data[g*2*D_SIZE +: 2*D_SIZE];
  end

  fifo_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Requests are only sampled in IDLE; anything raised during a transfer
  // waits, with no state kept for it.
  assign take_grant = (state == IDLE) && pick_found;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. A frame leaves only on a cycle with fifo_full low, so
  // each full cycle costs exactly one stall cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (take_grant) state_next = SEND_LO;
      SEND_LO: if (!fifo_full) state_next = hold_two ? SEND_HI : IDLE;
      SEND_HI: if (!fifo_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: w_inc is combinational so a full flag that rises this
  // cycle blocks the write this cycle.
  always_comb begin
    w_inc  = 1'b0;
    busy   = (state != IDLE);
    w_data = hold[D_SIZE-1:0];
    unique case (state)
      SEND_LO: w_inc = !fifo_full;
      SEND_HI: begin
        w_inc  = !fifo_full;
        w_data = hold[2*D_SIZE-1:D_SIZE];
      end
      default: w_inc = 1'b0;
    endcase
  end

  // Grant capture: holding register, pointer, grant index and ack pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the holding register is reset because it drives w_data, which
      // must read zero out of reset; a mid-transfer reset drops its payload.
      hold     <= '0;
      hold_two <= 1'b0;
      last     <= IDX_W'(N_REQ - 1);
      grant_id <= '0;
      ack      <= '0;
    end else begin
      ack <= '0;
      if (take_grant) begin
        hold          <= payload[pick_idx];
        hold_two      <= req_two[pick_idx];
        last          <= pick_idx;
        grant_id      <= pick_idx;
        ack[pick_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by a
// randomised run against a frame-level reference model and a FIFO model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int D     = 8;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      req_two;
  logic [N*2*D-1:0]  req_data;
  logic              fifo_full;
  logic [N-1:0]      ack;
  logic              w_inc;
  logic [D-1:0]      w_data;
  logic [1:0]        grant_id;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [2*D-1:0] pay [N];

  fifo_wr_arbiter #(.D_SIZE(D), .N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_two   (req_two),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .ack       (ack),
    .w_inc     (w_inc),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < N; i++) req_data[i*2*D +: 2*D] = pay[i];
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Random-phase model state
  int             rem;
  int             mlast;
  int             mgrant;
  int             issued;
  int             cyc;
  int             w;
  logic [N-1:0]   pending;
  logic [N-1:0]   cur_ack;
  logic [N-1:0]   next_ack;
  logic [D-1:0]   frames[$];
  logic [D-1:0]   fq[$];
  logic [D-1:0]   sb[$];
  logic [D-1:0]   got;
  logic [D-1:0]   exp_f;

  initial begin
    rst = 1'b1; req = '0; req_two = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) pay[i] = '0;
    settle();
    check("rst_ack", 32'(ack), 0);
    check("rst_winc", 32'(w_inc), 0);
    check("rst_wdata", 32'(w_data), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    step(); step();
    rst = 1'b0;

    // Single-frame request from requester 0
    req = 4'b0001; pay[0] = 16'h00A5; settle();
    check("t1_c0_busy", 32'(busy), 0);
    step(); req = '0; settle();
    check("t1_ack", 32'(ack), 32'b0001);
    check("t1_busy", 32'(busy), 1);
    check("t1_winc", 32'(w_inc), 1);
    check("t1_wdata", 32'(w_data), 32'hA5);
    step(); settle();
    check("t1_c2_busy", 32'(busy), 0);
    check("t1_c2_winc", 32'(w_inc), 0);

    // Two-frame request from requester 2
    req = 4'b0100; req_two = 4'b0100; pay[2] = 16'h3C5A; settle();
    step(); req = '0; settle();
    check("t2_ack", 32'(ack), 32'b0100);
    check("t2_grant", 32'(grant_id), 2);
    check("t2_lo_winc", 32'(w_inc), 1);
    check("t2_lo_data", 32'(w_data), 32'h5A);
    step(); settle();
    check("t2_hi_winc", 32'(w_inc), 1);
    check("t2_hi_data", 32'(w_data), 32'h3C);
    check("t2_hi_ack", 32'(ack), 0);
    step(); settle();
    check("t2_idle_busy", 32'(busy), 0);

    // Fairness: all requesting, rotation starts at 0 after reset
    rst = 1'b1; req_two = '0; settle(); step(); rst = 1'b0;
    for (int i = 0; i < N; i++) pay[i] = 16'(8'h10 + i);
    req = 4'b1111; settle();
    for (int g = 0; g < 8; g++) begin
      step();
      req = (g == 7) ? 4'b0000 : 4'b1111;
      settle();
      check("rr_ack", 32'(ack), 32'(1 << (g % N)));
      check("rr_grant", 32'(grant_id), 32'(g % N));
      check("rr_wdata", 32'(w_data), 32'(8'h10 + (g % N)));
      step(); settle();
      check("rr_idle", 32'(busy), 0);
    end

    // FIFO full for 3 cycles during the high frame of 16'hBEEF
    req = 4'b0010; req_two = 4'b0010; pay[1] = 16'hBEEF; settle();
    step(); req = '0; settle();
    check("full_ack", 32'(ack), 32'b0010);
    check("full_lo_data", 32'(w_data), 32'hEF);
    check("full_lo_winc", 32'(w_inc), 1);
    for (int s = 0; s < 3; s++) begin
      step(); fifo_full = 1'b1; settle();
      check("full_stall_winc", 32'(w_inc), 0);
      check("full_stall_data", 32'(w_data), 32'hBE);
      check("full_stall_busy", 32'(busy), 1);
    end
    step(); fifo_full = 1'b0; settle();
    check("full_release_winc", 32'(w_inc), 1);
    check("full_release_data", 32'(w_data), 32'hBE);
    step(); settle();
    check("full_done_busy", 32'(busy), 0);
    check("full_done_winc", 32'(w_inc), 0);

    // Reset in the middle of SEND_LO
    req = 4'b0001; req_two = '0; pay[0] = 16'h1234; settle();
    step(); req = '0; settle();
    check("mid_sendlo_busy", 32'(busy), 1);
    rst = 1'b1; settle();
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_winc", 32'(w_inc), 0);
    check("mid_rst_wdata", 32'(w_data), 0);
    check("mid_rst_grant", 32'(grant_id), 0);
    check("mid_rst_busy", 32'(busy), 0);
    step(); rst = 1'b0; req = 4'b1010; settle();
    step(); req = '0; settle();
    check("post_rst_ack", 32'(ack), 32'b0010);
    check("post_rst_grant", 32'(grant_id), 1);
    step(); settle();

    // Randomised run: 64 requests through a FIFO drained every third cycle
    rst = 1'b1; req = '0; req_two = '0; settle(); step(); rst = 1'b0;
    rem = 0; mlast = N - 1; mgrant = 0; issued = 0; cyc = 0;
    pending = '0; next_ack = '0;
    while (!(issued == 64 && pending == '0 && rem == 0 && next_ack == '0 && fq.size() == 0)) begin
      if (cyc >= 5000) begin
        check("random_timeout", 32'(cyc), 0);
        break;
      end
      cur_ack  = next_ack;
      next_ack = '0;
      pending  = pending & ~cur_ack;
      if (cyc % 3 == 0 && fq.size() > 0) begin
        got   = fq.pop_front();
        exp_f = sb.pop_front();
        check("read_order", 32'(got), 32'(exp_f));
      end
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && issued < 64 && ($urandom % 3 == 0)) begin
          pending[i] = 1'b1;
          req_two[i] = 1'($urandom);
          pay[i]     = 16'($urandom);
          issued++;
        end
      end
      req       = pending;
      fifo_full = (fq.size() == DEPTH);
      settle();
      check("rnd_ack", 32'(ack), 32'(cur_ack));
      check("rnd_grant", 32'(grant_id), 32'(mgrant));
      check("rnd_busy", 32'(busy), 32'(rem > 0));
      check("rnd_winc", 32'(w_inc), 32'(rem > 0 && !fifo_full));
      if (rem > 0) begin
        check("rnd_wdata", 32'(w_data), 32'(frames[0]));
        if (!fifo_full) begin
          fq.push_back(w_data);
          sb.push_back(frames.pop_front());
          rem--;
        end
      end else if (req != '0) begin
        w        = model_pick(req, mlast);
        mlast    = w;
        mgrant   = w;
        next_ack = N'(1) << w;
        frames.push_back(pay[w][D-1:0]);
        if (req_two[w]) frames.push_back(pay[w][2*D-1:D]);
        rem = frames.size();
      end
      step();
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
